// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl: pipeline stall/flush/forwarding scheduler with MDU wait FSM and stall-cycle counter
module hazard_sched_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Ins_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             MemRead_E,
  input  logic             mdu_op_E,
  input  logic             PCSrc_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int CW = MDU_LAT > 2 ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT > 1 ? MDU_LAT - 2 : 0);
  typedef enum logic {RUN, MDU_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [4:0] rs1_D, rs2_D;
  logic in_wait, mdu_busy, mdu_stall, lu, br;
  assign rs1_D = Ins_D[19:15];
  assign rs2_D = Ins_D[24:20];
  always_comb begin
    in_wait    = state == MDU_WAIT;
    mdu_busy   = in_wait || mdu_op_E;
    mdu_stall  = rst_n && (in_wait ? cnt != '0 : mdu_op_E && MDU_LAT > 1);
    mdu_done   = rst_n && (in_wait ? cnt == '0 : mdu_op_E && MDU_LAT == 1);
    br         = rst_n && !mdu_busy && PCSrc_E;
    lu         = rst_n && !mdu_busy && !PCSrc_E && MemRead_E && rd_E != '0 && (rd_E == rs1_D || rd_E == rs2_D);
    StallF     = mdu_stall || lu;
    StallD     = mdu_stall || lu;
    StallE     = mdu_stall;
    FlushD     = br;
    FlushE     = br || lu;
    FlushM     = mdu_stall;
    ForwardA_E = !rst_n ? 2'b00 :
                 (RegWrite_M && rd_M != '0 && rd_M == rs1_E) ? 2'b10 :
                 (RegWrite_W && rd_W != '0 && rd_W == rs1_E) ? 2'b01 : 2'b00;
    ForwardB_E = !rst_n ? 2'b00 :
                 (RegWrite_M && rd_M != '0 && rd_M == rs2_E) ? 2'b10 :
                 (RegWrite_W && rd_W != '0 && rd_W == rs2_E) ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else if (in_wait) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      else state <= RUN;
    end else if (mdu_op_E && MDU_LAT > 1) begin
      state <= MDU_WAIT;
      cnt   <= CNT_INIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (StallD && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// tb_hazard_sched_ctrl: scoreboard bench for hazard_sched_ctrl (MDU_LAT=4, CNT_W=4)
module tb_hazard_sched_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] Ins_D;
  logic [4:0] rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic MemRead_E, mdu_op_E, PCSrc_E, RegWrite_M, RegWrite_W;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_done;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic [3:0] stall_cnt;
  logic [10:0] obs;
  typedef struct {string tag; logic [10:0] o; logic [3:0] c;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  logic [3:0] mcnt = '0;
  always #5 clk = ~clk;
  hazard_sched_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Ins_D(Ins_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .MemRead_E(MemRead_E), .mdu_op_E(mdu_op_E), .PCSrc_E(PCSrc_E), .rd_M(rd_M), .rd_W(rd_W),
    .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
  );
  assign obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardA_E, ForwardB_E, mdu_done};
  function automatic logic [10:0] mk(input logic sf, sd, se, fd, fe, fm, input logic [1:0] fa, fb, input logic d);
    return {sf, sd, se, fd, fe, fm, fa, fb, d};
  endfunction
  function automatic logic [31:0] ins(input logic [4:0] r1, r2);
    return {7'd0, r2, r1, 15'd0};
  endfunction
  localparam logic [10:0] IDLE = 11'd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [10:0] o);
    exp_t e;
    e.tag = tag;
    e.o = o;
    e.c = mcnt;
    sb.push_back(e);
    if (o[9]) mcnt = (mcnt == 4'd15) ? 4'd15 : mcnt + 4'd1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    Ins_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
    MemRead_E = 0; mdu_op_E = 0; PCSrc_E = 0; RegWrite_M = 0; RegWrite_W = 0;
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, " ctl"}, {21'd0, obs}, {21'd0, e.o});
      check({e.tag, " cnt"}, {28'd0, stall_cnt}, {28'd0, e.c});
    end
  end
  initial begin
    logic [10:0] lu_o, br_o, ms_o, md_o;
    lu_o = mk(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0);
    br_o = mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0);
    ms_o = mk(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    md_o = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    idle_inputs();
    rd_M = 5'd7; RegWrite_M = 1; rs1_E = 5'd7; MemRead_E = 1; rd_E = 5'd5; Ins_D = ins(5'd5, 5'd1);
    #3;
    check("reset ctl", {21'd0, obs}, 32'd0);
    check("reset cnt", {28'd0, stall_cnt}, 32'd0);
    idle_inputs();
    #9 rst_n = 1;
    @(posedge clk); #1;
    step("idle", IDLE);
    MemRead_E = 1; rd_E = 5'd5; Ins_D = ins(5'd6, 5'd5) & 32'h0 | ins(5'd5, 5'd1);
    step("lu_rs1", lu_o);
    MemRead_E = 0;
    step("after_lu", IDLE);
    MemRead_E = 1; rd_E = 5'd6; Ins_D = ins(5'd2, 5'd6);
    step("lu_rs2", lu_o);
    rd_E = 5'd0; Ins_D = ins(5'd0, 5'd0);
    step("lu_x0", IDLE);
    MemRead_E = 0; rd_E = 5'd5; Ins_D = ins(5'd5, 5'd5);
    step("no_load", IDLE);
    idle_inputs();
    rd_M = 5'd7; rd_W = 5'd7; RegWrite_M = 1; RegWrite_W = 1; rs1_E = 5'd7; rs2_E = 5'd3;
    step("fwd_mem", mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    RegWrite_M = 0;
    step("fwd_wb", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
    rd_W = 5'd0;
    step("fwd_none", IDLE);
    rd_M = 5'd9; RegWrite_M = 1; rd_W = 5'd3; RegWrite_W = 1; rs1_E = 5'd3; rs2_E = 5'd9;
    step("fwd_mix", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0));
    rd_M = 5'd0; rd_W = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    step("fwd_x0", IDLE);
    idle_inputs();
    PCSrc_E = 1; MemRead_E = 1; rd_E = 5'd5; Ins_D = ins(5'd5, 5'd1);
    step("br_lu", br_o);
    MemRead_E = 0;
    step("br_only", br_o);
    idle_inputs();
    mdu_op_E = 1; PCSrc_E = 1; MemRead_E = 1; rd_E = 5'd5; Ins_D = ins(5'd5, 5'd1);
    step("mdu_s1", ms_o);
    PCSrc_E = 0; MemRead_E = 0;
    step("mdu_s2", ms_o);
    step("mdu_s3", ms_o);
    step("mdu_done", md_o);
    mdu_op_E = 0;
    step("mdu_after", IDLE);
    mdu_op_E = 1;
    step("mdu_r1", ms_o);
    rd_M = 5'd7; RegWrite_M = 1; rs1_E = 5'd7;
    #1 rst_n = 0;
    #1;
    check("mid_rst ctl", {21'd0, obs}, 32'd0);
    check("mid_rst cnt", {28'd0, stall_cnt}, 32'd0);
    idle_inputs();
    mcnt = '0;
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    step("post_rst", IDLE);
    MemRead_E = 1; rd_E = 5'd5; Ins_D = ins(5'd5, 5'd1);
    for (int i = 0; i < 19; i++) step("sat", lu_o);
    idle_inputs();
    step("sat_hold", IDLE);
    step("sat_hold2", IDLE);
    @(negedge clk); #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
